// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: per-stage hazard inputs in, stall/bubble/status/perf outputs back.
// The controller uses the slave modport; whoever drives the hazard inputs uses master.
interface pipe_ctrl_if;
  logic [3:0]  D_icode_i, E_icode_i, E_dstM_i, d_srcA_i, d_srcB_i, M_icode_i;
  logic        e_cnd_i;
  logic [2:0]  m_stat_i, W_stat_i;
  logic        dmem_busy_i;
  logic        F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
  logic        D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o;
  logic        halted_o;
  logic [2:0]  stat_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o, bubble_cnt_o;

  modport master (
    output D_icode_i, E_icode_i, E_dstM_i, d_srcA_i, d_srcB_i, M_icode_i,
           e_cnd_i, m_stat_i, W_stat_i, dmem_busy_i,
    input  F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
           halted_o, stat_o, cycle_cnt_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  D_icode_i, E_icode_i, E_dstM_i, d_srcA_i, d_srcB_i, M_icode_i,
           e_cnd_i, m_stat_i, W_stat_i, dmem_busy_i,
    output F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
           D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o,
           halted_o, stat_o, cycle_cnt_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-style pipeline hazard controller: load/use, ret, mispredict, memory wait, halt.
// Define PIPE_CTRL_PERF_CNT_EN to build the cycle/stall/bubble performance counters.
module pipe_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  pipe_ctrl_if.slave bus
);
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_JXX  = 4'h7,
                         I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ = 4'hA,
                         I_POPQ   = 4'hB, R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1, S_ADR = 3'd3;
  localparam logic [7:0] TMO_LAST = 8'd254;

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  typedef struct packed {
    logic f_stall, d_stall, e_stall, m_stall, w_stall;
    logic d_bubble, e_bubble, m_bubble, w_bubble;
  } ctl_t;

  state_t     state, state_nxt;
  logic [7:0] tmo, tmo_nxt;
  logic [2:0] stat_q, stat_nxt;
  ctl_t       ctl, ctl_q;

  logic loaduse, ret, mispredict, w_exc, m_exc, mem_op, busy;

  assign busy       = bus.dmem_busy_i;
  assign loaduse    = (bus.E_icode_i == I_MRMOVQ || bus.E_icode_i == I_POPQ) &&
                      bus.E_dstM_i != R_NONE &&
                      (bus.E_dstM_i == bus.d_srcA_i || bus.E_dstM_i == bus.d_srcB_i);
  assign ret        = bus.D_icode_i == I_RET || bus.E_icode_i == I_RET ||
                      bus.M_icode_i == I_RET;
  assign mispredict = bus.E_icode_i == I_JXX && !bus.e_cnd_i;
  assign w_exc      = bus.W_stat_i != S_AOK;
  assign m_exc      = bus.m_stat_i != S_AOK;
  assign mem_op     = bus.M_icode_i inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= RUN;
      tmo    <= '0;
      stat_q <= S_AOK;
    end else begin
      state  <= state_nxt;
      tmo    <= tmo_nxt;
      stat_q <= stat_nxt;
    end
  end

  // MEMWAIT only freezes while the access is still outstanding; once busy drops
  // the pipeline advances that cycle and the controller behaves exactly as in RUN.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    stat_nxt  = stat_q;
    ctl       = '0;
    case (state)
      HALT: begin
        ctl.f_stall = 1'b1; ctl.d_stall = 1'b1; ctl.e_stall = 1'b1;
        ctl.m_stall = 1'b1; ctl.w_stall = 1'b1;
      end
      MEMWAIT: begin
        if (busy) begin
          ctl.f_stall = 1'b1; ctl.d_stall = 1'b1; ctl.e_stall = 1'b1;
          ctl.m_stall = 1'b1; ctl.w_bubble = 1'b1;
          tmo_nxt = 8'(tmo + 8'd1);
          if (tmo == TMO_LAST) begin
            state_nxt = HALT;
            stat_nxt  = S_ADR;
          end
        end else begin
          state_nxt = RUN;
          ctl.f_stall  = loaduse | ret;
          ctl.d_stall  = loaduse;
          ctl.d_bubble = mispredict | (ret & ~loaduse);
          ctl.e_bubble = mispredict | loaduse;
          ctl.m_bubble = m_exc | w_exc;
          ctl.w_stall  = w_exc;
        end
      end
      default: begin
        // A writeback exception wins over a simultaneous memory wait.
        if (w_exc) begin
          state_nxt = HALT;
          stat_nxt  = bus.W_stat_i;
        end else if (busy && mem_op) begin
          state_nxt = MEMWAIT;
          tmo_nxt   = '0;
        end
        if (!w_exc && busy && mem_op) begin
          ctl.f_stall = 1'b1; ctl.d_stall = 1'b1; ctl.e_stall = 1'b1;
          ctl.m_stall = 1'b1; ctl.w_bubble = 1'b1;
        end else begin
          ctl.f_stall  = loaduse | ret;
          ctl.d_stall  = loaduse;
          ctl.d_bubble = mispredict | (ret & ~loaduse);
          ctl.e_bubble = mispredict | loaduse;
          ctl.m_bubble = m_exc | w_exc;
          ctl.w_stall  = w_exc;
        end
      end
    endcase
  end

  // Reset must silence the combinational outputs without waiting for an edge.
  assign ctl_q = rst_n_i ? ctl : '0;

  assign bus.F_stall_o  = ctl_q.f_stall;
  assign bus.D_stall_o  = ctl_q.d_stall;
  assign bus.E_stall_o  = ctl_q.e_stall;
  assign bus.M_stall_o  = ctl_q.m_stall;
  assign bus.W_stall_o  = ctl_q.w_stall;
  assign bus.D_bubble_o = ctl_q.d_bubble;
  assign bus.E_bubble_o = ctl_q.e_bubble;
  assign bus.M_bubble_o = ctl_q.m_bubble;
  assign bus.W_bubble_o = ctl_q.w_bubble;
  assign bus.halted_o   = state == HALT;
  assign bus.stat_o     = (state == HALT) ? stat_q : S_AOK;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;
  logic        any_stall, any_bubble;

  assign any_stall  = |{ctl_q.f_stall, ctl_q.d_stall, ctl_q.e_stall, ctl_q.m_stall, ctl_q.w_stall};
  assign any_bubble = |{ctl_q.d_bubble, ctl_q.e_bubble, ctl_q.m_bubble, ctl_q.w_bubble};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (state != HALT) begin
      if (cycle_cnt != '1)                 cycle_cnt  <= cycle_cnt + 32'd1;
      if (any_stall  && stall_cnt  != '1) stall_cnt  <= stall_cnt + 32'd1;
      if (any_bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt_o  = cycle_cnt;
  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.bubble_cnt_o = bubble_cnt;
`else
  assign bus.cycle_cnt_o  = '0;
  assign bus.stall_cnt_o  = '0;
  assign bus.bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; control vector order is
// {F,D,E,M,W stall, D,E,M,W bubble}.
module tb_pipe_ctrl;
  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pipe_ctrl_if bus();
  pipe_ctrl dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] C_NONE = 9'b00000_0000, C_LU   = 9'b11000_0100,
                         C_MPR  = 9'b10000_1100, C_RETM = 9'b10000_1000,
                         C_FRZ  = 9'b11110_0001, C_HALT = 9'b11111_0000,
                         C_MEXC = 9'b00000_0010, C_WEXC = 9'b00001_0010;

  function automatic logic [8:0] ctl();
    return {bus.F_stall_o, bus.D_stall_o, bus.E_stall_o, bus.M_stall_o, bus.W_stall_o,
            bus.D_bubble_o, bus.E_bubble_o, bus.M_bubble_o, bus.W_bubble_o};
  endfunction

  task automatic idle();
    bus.D_icode_i = 4'h0; bus.E_icode_i = 4'h0; bus.M_icode_i = 4'h0;
    bus.E_dstM_i  = 4'hF; bus.d_srcA_i  = 4'hF; bus.d_srcB_i  = 4'hF;
    bus.e_cnd_i   = 1'b1; bus.m_stat_i  = 3'd1; bus.W_stat_i  = 3'd1;
    bus.dmem_busy_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Short reset pulse placed between edges (called at a falling edge).
  task automatic pulse_reset();
    rst_n_i = 1'b0;
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3;
    @(negedge clk_i); #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL reset_ctl got %b want %b", ctl(), C_NONE); end
    total++; if (bus.stat_o !== 3'd1) begin bad++; $display("FAIL reset_stat got %0d want 1", bus.stat_o); end
    total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted got %b want 0", bus.halted_o); end
    total++; if ({bus.cycle_cnt_o, bus.stall_cnt_o, bus.bubble_cnt_o} !== 96'd0) begin
      bad++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", bus.cycle_cnt_o, bus.stall_cnt_o, bus.bubble_cnt_o);
    end
    idle();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_loaduse();
    idle(); bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3; #1;
    total++; if (ctl() !== C_LU) begin bad++; $display("FAIL loaduse_srcA got %b want %b", ctl(), C_LU); end
    idle(); bus.E_icode_i = 4'hB; bus.E_dstM_i = 4'h6; bus.d_srcB_i = 4'h6; #1;
    total++; if (ctl() !== C_LU) begin bad++; $display("FAIL loaduse_popq_srcB got %b want %b", ctl(), C_LU); end
    // dstM of "none" must not match a "none" source
    idle(); bus.E_icode_i = 4'h5; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL loaduse_none got %b want %b", ctl(), C_NONE); end
    idle(); bus.E_icode_i = 4'h2; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL loaduse_nonload got %b want %b", ctl(), C_NONE); end
    idle(); step();
  endtask

  task automatic test_ret_mispredict();
    idle(); bus.E_icode_i = 4'h7; bus.e_cnd_i = 1'b0; bus.D_icode_i = 4'h9; #1;
    total++; if (ctl() !== C_MPR) begin bad++; $display("FAIL mispredict_ret got %b want %b", ctl(), C_MPR); end
    idle(); bus.M_icode_i = 4'h9; #1;
    total++; if (ctl() !== C_RETM) begin bad++; $display("FAIL ret_in_m got %b want %b", ctl(), C_RETM); end
    idle(); bus.E_icode_i = 4'h7; bus.e_cnd_i = 1'b1; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL jxx_taken got %b want %b", ctl(), C_NONE); end
    idle(); bus.m_stat_i = 3'd3; #1;
    total++; if (ctl() !== C_MEXC) begin bad++; $display("FAIL m_exc got %b want %b", ctl(), C_MEXC); end
    step();
    total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL m_exc_nohalt got %b want 0", bus.halted_o); end
    idle(); step();
  endtask

  task automatic test_memwait();
    idle(); bus.M_icode_i = 4'h6; bus.dmem_busy_i = 1'b1; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL busy_nonmem got %b want %b", ctl(), C_NONE); end
    bus.M_icode_i = 4'h5; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (ctl() !== C_FRZ) begin bad++; $display("FAIL memwait_cyc%0d got %b want %b", i, ctl(), C_FRZ); end
      step();
    end
    bus.dmem_busy_i = 1'b0; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL memwait_done got %b want %b", ctl(), C_NONE); end
    step();
    bus.M_icode_i = 4'h0; bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h2; bus.d_srcB_i = 4'h2; #1;
    total++; if (ctl() !== C_LU) begin bad++; $display("FAIL memwait_back_run got %b want %b", ctl(), C_LU); end
    idle(); step();
  endtask

  task automatic test_timeout();
    pulse_reset();
    idle(); bus.M_icode_i = 4'h5; bus.dmem_busy_i = 1'b1;
    step();
    repeat (254) step();
    total++; if (bus.halted_o !== 1'b0 || ctl() !== C_FRZ) begin
      bad++; $display("FAIL timeout_early halted %b ctl %b want 0 %b", bus.halted_o, ctl(), C_FRZ);
    end
    step();
    total++; if (bus.halted_o !== 1'b1) begin bad++; $display("FAIL timeout_halted got %b want 1", bus.halted_o); end
    total++; if (bus.stat_o !== 3'd3) begin bad++; $display("FAIL timeout_stat got %0d want 3", bus.stat_o); end
    total++; if (ctl() !== C_HALT) begin bad++; $display("FAIL timeout_ctl got %b want %b", ctl(), C_HALT); end
    idle(); pulse_reset(); step();
  endtask

  task automatic test_reset_midwait();
    idle(); bus.M_icode_i = 4'h5; bus.dmem_busy_i = 1'b1;
    step();
    repeat (100) step();
    rst_n_i = 1'b0; #1;
    total++; if (ctl() !== C_NONE) begin bad++; $display("FAIL midwait_rst_ctl got %b want %b", ctl(), C_NONE); end
    rst_n_i = 1'b1;
    step();
    repeat (254) step();
    total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL midwait_residual halted %b want 0", bus.halted_o); end
    idle(); step();
    total++; if (ctl() !== C_NONE || bus.halted_o !== 1'b0) begin
      bad++; $display("FAIL midwait_resume ctl %b halted %b want %b 0", ctl(), bus.halted_o, C_NONE);
    end
  endtask

  task automatic test_halt();
    idle(); bus.W_stat_i = 3'd2; #1;
    total++; if (ctl() !== C_WEXC || bus.halted_o !== 1'b0 || bus.stat_o !== 3'd1) begin
      bad++; $display("FAIL wexc_same ctl %b halted %b stat %0d want %b 0 1", ctl(), bus.halted_o, bus.stat_o, C_WEXC);
    end
    step();
    idle(); bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3; #1;
    total++; if (bus.halted_o !== 1'b1 || bus.stat_o !== 3'd2) begin
      bad++; $display("FAIL halt_entry halted %b stat %0d want 1 2", bus.halted_o, bus.stat_o);
    end
    total++; if (ctl() !== C_HALT) begin bad++; $display("FAIL halt_ctl got %b want %b", ctl(), C_HALT); end
    repeat (3) step();
    total++; if (bus.stat_o !== 3'd2 || bus.halted_o !== 1'b1) begin
      bad++; $display("FAIL halt_held stat %0d halted %b want 2 1", bus.stat_o, bus.halted_o);
    end
    rst_n_i = 1'b0; #1;
    total++; if (ctl() !== C_NONE || bus.halted_o !== 1'b0 || bus.stat_o !== 3'd1) begin
      bad++; $display("FAIL halt_rst ctl %b halted %b stat %0d want %b 0 1", ctl(), bus.halted_o, bus.stat_o, C_NONE);
    end
    rst_n_i = 1'b1; #1;
    total++; if (ctl() !== C_LU) begin bad++; $display("FAIL halt_rst_run got %b want %b", ctl(), C_LU); end
    step();
    total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL halt_rst_state got %b want 0", bus.halted_o); end
    idle(); step();
  endtask

  task automatic test_priority();
    idle(); bus.M_icode_i = 4'h5; bus.dmem_busy_i = 1'b1; bus.W_stat_i = 3'd4;
    step();
    idle(); #1;
    total++; if (bus.halted_o !== 1'b1 || bus.stat_o !== 3'd4 || ctl() !== C_HALT) begin
      bad++; $display("FAIL wexc_busy halted %b stat %0d ctl %b want 1 4 %b", bus.halted_o, bus.stat_o, ctl(), C_HALT);
    end
    pulse_reset(); step();
  endtask

  task automatic test_perf();
    logic [31:0] exp_c, exp_s, exp_b;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_c = 32'd10; exp_s = 32'd2; exp_b = 32'd2;
`else
    exp_c = 32'd0;  exp_s = 32'd0; exp_b = 32'd0;
`endif
    idle(); pulse_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 3 || i == 4) begin
        bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h1; bus.d_srcA_i = 4'h1;
      end
      step();
    end
    idle(); #1;
    total++; if (bus.cycle_cnt_o !== exp_c) begin bad++; $display("FAIL perf_cycle got %0d want %0d", bus.cycle_cnt_o, exp_c); end
    total++; if (bus.stall_cnt_o !== exp_s) begin bad++; $display("FAIL perf_stall got %0d want %0d", bus.stall_cnt_o, exp_s); end
    total++; if (bus.bubble_cnt_o !== exp_b) begin bad++; $display("FAIL perf_bubble got %0d want %0d", bus.bubble_cnt_o, exp_b); end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_ret_mispredict();
    test_memwait();
    test_timeout();
    test_reset_midwait();
    test_halt();
    test_priority();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the ports below; one clock; reset asynchronous, active-low.
- clk_i  in  1  pipeline clock.
- rst_n_i  in  1  asynchronous active-low reset.
- D_icode_i  in  4  icode in decode stage.
- E_icode_i  in  4  icode in execute stage.
- E_dstM_i  in  4  execute-stage dstM (0xF = none).
- d_srcA_i, d_srcB_i  in  4 each  decode-stage source registers (0xF = none).
- M_icode_i  in  4  icode in memory stage.
- e_cnd_i  in  1  branch condition from execute.
- m_stat_i, W_stat_i  in  3 each  memory/writeback status (AOK=1, HLT=2, ADR=3, INS=4).
- dmem_busy_i  in  1  data memory has not completed the current access.
- F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o  out  1 each  hold stage register.
- D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o  out  1 each  load NOP into stage register.
- halted_o  out  1  pipeline frozen.
- stat_o  out  3  latched processor status.
- cycle_cnt_o, stall_cnt_o, bubble_cnt_o  out  32 each  performance counters (REQ-021).

Function
REQ-002 SHALL implement FSM states RUN, MEMWAIT and HALT; the reset state SHALL be RUN.
REQ-003 Load/use SHALL be true when E_icode_i is in {5 MRMOVQ, B POPQ}, E_dstM_i != F, and E_dstM_i equals d_srcA_i or d_srcB_i.
REQ-004 Ret SHALL be true when icode 9 (RET) is in D, E or M; mispredict SHALL be true when E_icode_i == 7 (JXX) and e_cnd_i == 0.
REQ-005 In RUN, the outputs SHALL be combinational in the same cycle: F_stall = loaduse|ret; D_stall = loaduse; D_bubble = mispredict|(ret & !loaduse); E_bubble = mispredict|loaduse.
REQ-006 In RUN, M_bubble SHALL equal (m_stat_i != AOK)|(W_stat_i != AOK), and W_stall SHALL equal (W_stat_i != AOK).
REQ-007 Outputs not named in REQ-005/006 SHALL be 0 in RUN; no stage SHALL see stall and bubble asserted together.
REQ-008 RUN SHALL go to MEMWAIT when dmem_busy_i=1 and M_icode_i is in {4 RMMOVQ, 5 MRMOVQ, 8 CALL, 9 RET, A PUSHQ, B POPQ}. The freeze of REQ-009 SHALL apply in that same cycle.
REQ-009 In MEMWAIT: F_stall, D_stall, E_stall, M_stall = 1; W_bubble = 1; all other stall/bubble outputs = 0. MEMWAIT SHALL return to RUN in the cycle after dmem_busy_i falls.
REQ-010 A MEMWAIT timeout counter (8-bit) SHALL clear on entry and increment each MEMWAIT cycle. On reaching 255 with dmem_busy_i still 1, the FSM SHALL go to HALT and stat_o SHALL be set to ADR.
REQ-011 RUN SHALL go to HALT on the clock edge where W_stat_i != AOK, and stat_o SHALL latch W_stat_i.
REQ-012 In HALT: all five stall outputs = 1, all bubbles = 0, halted_o = 1. HALT SHALL be exited only by reset.
REQ-013 Priority SHALL be HALT > MEMWAIT > REQ-006 > REQ-005.
REQ-014 W_stat_i exception and dmem_busy_i asserted in the same cycle SHALL take HALT.
REQ-015 stat_o SHALL read AOK while not in HALT.

Reset
REQ-016 While rst_n_i=0: state = RUN, timeout = 0, all stall/bubble outputs = 0, halted_o = 0, stat_o = AOK, counters = 0. This SHALL take effect immediately, without waiting for a clock edge.
REQ-017 Reset asserted mid-MEMWAIT or in HALT SHALL abort to RUN with no residual timeout count.
REQ-018 After rst_n_i rises, the first clock edge SHALL be evaluated as RUN.

Configuration
REQ-019 Macro PIPE_CTRL_PERF_CNT_EN SHALL select counter support.
REQ-020 Without the macro, cycle_cnt_o, stall_cnt_o and bubble_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.
REQ-021 With the macro, counters SHALL increment once per clock edge while not halted: cycle always; stall if any stall output = 1; bubble if any bubble output = 1. Each SHALL saturate at 0xFFFFFFFF.

Verification
REQ-022 E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-023 E_icode=7, e_cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1, D_stall=0.
REQ-024 M_icode=5 with dmem_busy_i high for 3 cycles -> F/D/E/M stall and W_bubble for 3 cycles, RUN on the 4th cycle, timeout never reached.
REQ-025 dmem_busy_i held high for 300 cycles -> HALT after 255 MEMWAIT cycles, stat_o=3, halted_o=1, all stalls=1.
REQ-026 W_stat_i=2 for one cycle -> halted_o=1 from the next edge, stat_o=2 held. Then rst_n_i pulsed low -> outputs 0, stat_o=1, state RUN.
REQ-027 With PIPE_CTRL_PERF_CNT_EN, 10 cycles including 2 load/use cycles -> cycle_cnt_o=10, stall_cnt_o=2, bubble_cnt_o=2. Without the macro, all counters read 0.
